// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the boot-time instruction memory loader.
//   state_t        : loader FSM states (CHECK exists only when the optional
//                    trailer checksum is built in)
//   BYTES_PER_WORD : bytes packed into one instruction word
//   WORD_W         : instruction word width
//   ADDR_SHIFT     : word index -> byte address shift
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned ADDR_SHIFT     = 2;
   localparam int unsigned LANE_W         = 2;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;
`endif

   // Modulo-256 running sum used for the program trailer byte.
   function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_word_packer
// Packs accepted bytes little-endian into one instruction word.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of count, word and full flag (wins over accept)
//   accept     : a byte handshake happens this cycle
//   data       : byte payload
//   word       : packed word (registered); first byte ends up in [7:0]
//   word_full  : registered, high the cycle after the 4th byte was accepted
//   last_lane  : the next accepted byte completes the word
// -----------------------------------------------------------------------------
module imem_loader_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        data,
   output logic [WORD_W-1:0] word,
   output logic              word_full,
   output logic              last_lane
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

   logic [LANE_W-1:0] byte_cnt_r;
   logic [WORD_W-1:0] word_r;
   logic              full_r;

   // Byte counter, lane shift register and word-complete flag.
   // Shifting in from the top places byte0 in [7:0] once four bytes are in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_r <= {LANE_W{1'b0}};
         word_r     <= {WORD_W{1'b0}};
         full_r     <= 1'b0;
      end else if (clear) begin
         byte_cnt_r <= {LANE_W{1'b0}};
         word_r     <= {WORD_W{1'b0}};
         full_r     <= 1'b0;
      end else if (accept) begin
         word_r     <= {data, word_r[WORD_W-1:8]};
         byte_cnt_r <= byte_cnt_r + LANE_W'(1);
         full_r     <= (byte_cnt_r == LAST_LANE);
      end else begin
         byte_cnt_r <= byte_cnt_r;
         word_r     <= word_r;
         full_r     <= full_r;
      end
   end

   assign word      = word_r;
   assign word_full = full_r;
   assign last_lane = (byte_cnt_r == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time program loader: receives a byte stream over valid/ready, packs it
// into 32-bit instructions, writes them to sequential word addresses of the
// instruction memory and holds the CPU in reset until the program is loaded.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, abort : one-cycle control pulses (abort wins over start)
//   num_words    : program length in words, sampled on an accepted start
//   in_valid/in_ready/in_data : byte stream handshake
//   wr_en/wr_addr/wr_data     : instruction memory write port
//   busy, done, error         : load status (error sticky until accepted start)
//   cpu_rst_n                 : active-low CPU reset, released only on success
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- adds a CHECK state that
// accepts one trailer byte which must equal the modulo-256 sum of the payload.
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned CNT_W     = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [31:0]       wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_rst_n
);

   localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] ONE       = {{(CNT_W - 1){1'b0}}, 1'b1};
   localparam int unsigned      PAD_W     = 32 - CNT_W - ADDR_SHIFT;

   state_t           state_r, state_next;
   logic [CNT_W-1:0] num_words_r, num_words_next;
   logic [CNT_W-1:0] word_idx_r, word_idx_next;
   logic [31:0]      wr_addr_r, wr_addr_next;
   logic             busy_r, busy_next;
   logic             done_r, done_next;
   logic             error_r, error_next;
   logic             cpu_rst_n_r, cpu_rst_n_next;
   logic             pack_clear, pack_accept;
   logic             pack_full, pack_last;
   logic [WORD_W-1:0] pack_word;
   logic             start_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       sum_r, sum_next;
`endif

   assign start_bad = (num_words == {CNT_W{1'b0}}) || ({1'b0, num_words} > DEPTH_LIM);

   imem_loader_word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pack_clear),
      .accept    (pack_accept),
      .data      (in_data),
      .word      (pack_word),
      .word_full (pack_full),
      .last_lane (pack_last)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state, next status values and packer control.
   always_comb begin
      state_next     = state_r;
      num_words_next = num_words_r;
      word_idx_next  = word_idx_r;
      wr_addr_next   = wr_addr_r;
      busy_next      = busy_r;
      done_next      = done_r;
      error_next     = error_r;
      cpu_rst_n_next = cpu_rst_n_r;
      pack_clear     = 1'b0;
      pack_accept    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_next       = sum_r;
`endif
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start && start_bad) begin
               state_next     = ERR;
               busy_next      = 1'b0;
               done_next      = 1'b0;
               error_next     = 1'b1;
               cpu_rst_n_next = 1'b0;
            end else if (start) begin
               state_next     = RECV;
               num_words_next = num_words;
               word_idx_next  = {CNT_W{1'b0}};
               busy_next      = 1'b1;
               done_next      = 1'b0;
               error_next     = 1'b0;
               cpu_rst_n_next = 1'b0;
               pack_clear     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_next       = 8'h00;
`endif
            end else begin
               state_next = state_r;
            end
         end
         RECV: begin
            if (abort) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               pack_clear = 1'b1;
            end else if (in_valid) begin
               pack_accept = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_next    = sum8(sum_r, in_data);
`endif
               if (pack_last) begin
                  // Address is captured together with the last byte so the
                  // write port is fully registered in the WRITE cycle.
                  state_next   = WRITE;
                  wr_addr_next = {{PAD_W{1'b0}}, word_idx_r, {ADDR_SHIFT{1'b0}}};
               end else begin
                  state_next = RECV;
               end
            end else begin
               state_next = RECV;
            end
         end
         WRITE: begin
            // The packer's full flag is the write strobe; clearing here keeps
            // it a single-cycle pulse.
            pack_clear = 1'b1;
            if (abort) begin
               state_next = IDLE;
               busy_next  = 1'b0;
            end else if (word_idx_r == (num_words_r - ONE)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_next     = CHECK;
`else
               state_next     = DONE;
               busy_next      = 1'b0;
               done_next      = 1'b1;
               cpu_rst_n_next = 1'b1;
`endif
            end else begin
               state_next    = RECV;
               word_idx_next = word_idx_r + ONE;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (abort) begin
               state_next = IDLE;
               busy_next  = 1'b0;
            end else if (in_valid && (in_data == sum_r)) begin
               state_next     = DONE;
               busy_next      = 1'b0;
               done_next      = 1'b1;
               cpu_rst_n_next = 1'b1;
            end else if (in_valid) begin
               state_next     = ERR;
               busy_next      = 1'b0;
               error_next     = 1'b1;
               cpu_rst_n_next = 1'b0;
            end else begin
               state_next = CHECK;
            end
         end
`endif
         default: begin
            state_next     = IDLE;
            busy_next      = 1'b0;
            cpu_rst_n_next = 1'b0;
            pack_clear     = 1'b1;
         end
      endcase
   end

   // Registered status, word counter and write address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_words_r <= {CNT_W{1'b0}};
         word_idx_r  <= {CNT_W{1'b0}};
         wr_addr_r   <= 32'h0000_0000;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         cpu_rst_n_r <= 1'b0;
      end else begin
         num_words_r <= num_words_next;
         word_idx_r  <= word_idx_next;
         wr_addr_r   <= wr_addr_next;
         busy_r      <= busy_next;
         done_r      <= done_next;
         error_r     <= error_next;
         cpu_rst_n_r <= cpu_rst_n_next;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running payload checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r <= 8'h00;
      end else begin
         sum_r <= sum_next;
      end
   end

   assign in_ready = (state_r == RECV) || (state_r == CHECK);
`else
   assign in_ready = (state_r == RECV);
`endif

   assign wr_en     = pack_full;
   assign wr_data   = pack_word;
   assign wr_addr   = wr_addr_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign cpu_rst_n = cpu_rst_n_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: table of whole-load vectors plus hand
// sequences for abort, mid-load reset and (with IMEM_LOADER_CHECKSUM_EN) the
// trailer checksum. Expected writes are queued as bytes are handed over and
// popped by a monitor whenever wr_en is seen.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int MEM_DEPTH = 256;
   localparam int CNT_W     = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] num_words = '0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = 8'h00;
   logic             in_ready, wr_en, busy, done, error, cpu_rst_n;
   logic [31:0]      wr_addr, wr_data;

   imem_loader #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_words(num_words), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } wr_exp_t;

   typedef struct {
      int          nw;
      bit          good;
      int          gap;
      logic [63:0] bytes;
      logic        exp_done;
      logic        exp_err;
      logic        exp_cpu;
   } load_vec_t;

   wr_exp_t     exp_q[$];
   wr_exp_t     mon_e;
   load_vec_t   vecs[6];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wr_count = 0;
   int          lane, widx;
   logic [31:0] cur_word;
   logic [7:0]  sum;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string name, input logic b, input logic d,
                               input logic e, input logic c);
      check(name, 64'({busy, done, error, cpu_rst_n}), 64'({b, d, e, c}));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every wr_en must match the oldest expected write.
   always @(negedge clk) begin
      if (wr_en) begin
         wr_count++;
         check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
            check("wr_data", 64'(wr_data), 64'(mon_e.data));
            check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic pulse_start(input int nw);
      start     = 1'b1;
      num_words = CNT_W'(nw);
      @(posedge clk); #1;
      start    = 1'b0;
      lane     = 0;
      widx     = 0;
      cur_word = 32'h0;
      sum      = 8'h00;
   endtask

   // Offers one byte and waits for its handshake; payload bytes build the
   // expected word and queue the write due the cycle after the 4th byte.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit payload);
      in_valid = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (payload) begin
               cur_word[8*lane +: 8] = b;
               sum = sum + b;
               lane++;
               if (lane == 4) begin
                  exp_q.push_back('{addr: 32'(widx * 4), data: cur_word, cyc: 32'(cyc)});
                  widx++;
                  lane = 0;
               end
            end
            return;
         end
      end
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("busy_timeout", 64'(busy), 64'd0);
   endtask

   task automatic run_vec(input load_vec_t v);
      int wr0;
      wr0 = wr_count;
      pulse_start(v.nw);
      @(negedge clk);
      if (v.good) begin
         check_status("start_status", 1'b1, 1'b0, 1'b0, 1'b0);
         check("start_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
         for (int i = 0; i < v.nw * 4; i++)
            send_byte(v.bytes[8*i +: 8], (v.gap > 0) ? int'($urandom_range(v.gap, 0)) : 0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(sum, 0, 1'b0);
`endif
         wait_idle();
         check("wr_count", 64'(wr_count - wr0), 64'(v.nw));
      end else begin
         for (int i = 0; i < 4; i++) begin
            check("bad_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
         end
         check("bad_wr_count", 64'(wr_count - wr0), 64'd0);
      end
      check_status("end_status", 1'b0, v.exp_done, v.exp_err, v.exp_cpu);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "global timeout");
   end

   initial begin
      int wr0;
      vecs[0] = '{2,   1'b1, 0, 64'h00100093_00000013, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{2,   1'b1, 5, 64'h00100093_00000013, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{0,   1'b0, 0, 64'h0,                 1'b0, 1'b1, 1'b0};
      vecs[3] = '{257, 1'b0, 0, 64'h0,                 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1,   1'b1, 2, 64'h00000000_00001237, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1,   1'b1, 0, 64'h00000000_deadbeef, 1'b1, 1'b0, 1'b1};

      // Reset state
      #2;
      check("rst_addr", 64'(wr_addr), 64'd0);
      check("rst_data", 64'(wr_data), 64'd0);
      check("rst_ctl", 64'({in_ready, wr_en, busy, done, error, cpu_rst_n}), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort after 6 bytes of a 3-word load, with start in the same cycle.
      wr0 = wr_count;
      pulse_start(3);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 0, 1'b1);
      abort = 1'b1; start = 1'b1; num_words = CNT_W'(1);
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      @(negedge clk);
      check_status("abort_status", 1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      repeat (5) @(negedge clk);
      check("abort_wr_count", 64'(wr_count - wr0), 64'd1);
      @(posedge clk); #1;

      // Reset in the middle of a new load.
      pulse_start(2);
      send_byte(8'haa, 0, 1'b1);
      send_byte(8'h55, 0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_addr", 64'(wr_addr), 64'd0);
      check("midrst_data", 64'(wr_data), 64'd0);
      check("midrst_ctl", 64'({in_ready, wr_en, busy, done, error, cpu_rst_n}), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(vecs[4]);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Trailer checksum: 01+02+03+04 = 0x0A.
      for (int k = 0; k < 2; k++) begin
         pulse_start(1);
         send_byte(8'h01, 0, 1'b1);
         send_byte(8'h02, 0, 1'b1);
         send_byte(8'h03, 1, 1'b1);
         send_byte(8'h04, 0, 1'b1);
         send_byte((k == 0) ? 8'h0a : 8'h0b, 2, 1'b0);
         wait_idle();
         if (k == 0) check_status("csum_ok", 1'b0, 1'b1, 1'b0, 1'b1);
         else        check_status("csum_bad", 1'b0, 1'b0, 1'b1, 1'b0);
         @(posedge clk); #1;
      end
`endif

      repeat (3) @(negedge clk);
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
